// File: rtl/end_screen_sequencer_pkg.sv
// Shared types and constants for the end-screen sequencer: FSM states,
// result codes and the two fixed colours the pixel path can emit.
package end_screen_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHOW  = 2'd1,
    WAIT  = 2'd2,
    CLEAR = 2'd3
  } state_e;

  localparam logic [1:0] RES_TOO_EARLY = 2'd0;
  localparam logic [1:0] RES_WIN       = 2'd1;
  localparam logic [1:0] RES_LOSE      = 2'd2;

  localparam logic [15:0] BLACK = 16'h0000;
  localparam logic [15:0] WHITE = 16'hFFFF;

endpackage : end_screen_pkg

// File: rtl/end_screen_sequencer_frame_tick_counter.sv
// Frame counter advanced by frame_begin, wrapping to zero at limit_i.
// tc_o flags the frame_begin that performs the wrap.
module frame_tick_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en_i,
  input  logic             clr_i,
  input  logic [CNT_W-1:0] limit_i,
  output logic             tc_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             at_limit;

  assign at_limit = (cnt_q == limit_i);
  assign tc_o     = en_i && at_limit && !clr_i;

  // Wrapping at the compare value keeps the count bounded below 2**CNT_W.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = at_limit ? '0 : cnt_q + 1'b1;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values; blocking here would create order-dependent simulation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule : frame_tick_counter

// File: rtl/end_screen_sequencer.sv
// End-of-game OLED pixel sequencer: live pixels, hold screen, wait for button,
// one blank frame, then back to live. Optional macro: INVERT_BLINK_EN.
module end_screen_sequencer
  import end_screen_pkg::*;
#(
  parameter int HOLD_FRAMES  = 120,
  parameter int BLINK_FRAMES = 15,
  parameter int CNT_W        = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        frame_begin,
  input  logic        game_over,
  input  logic [1:0]  result,
  input  logic        btn_continue,
  input  logic [15:0] game_pixel,
  input  logic [15:0] end_pixel0,
  input  logic [15:0] end_pixel1,
  input  logic [15:0] end_pixel2,
  output logic [15:0] oled_data,
  output logic        busy,
  output logic        done
);

  localparam logic [CNT_W-1:0] HOLD_LIMIT  = CNT_W'(HOLD_FRAMES - 1);
  localparam logic [CNT_W-1:0] BLINK_LIMIT = CNT_W'(BLINK_FRAMES - 1);

  state_e      state_q, state_d;
  logic [1:0]  result_q, result_d;
  logic        pend_q, pend_d;
  logic [15:0] oled_q, oled_d;
  logic        done_q, done_d;

  logic        cnt_en;
  logic        cnt_clr;
  logic [CNT_W-1:0] cnt_limit;
  logic        tc;
  logic [15:0] sel_pixel;
  logic [15:0] wait_pixel;

  // The same counter times the hold in SHOW and the blink period in WAIT.
  assign cnt_en    = frame_begin && ((state_q == SHOW) || (state_q == WAIT));
  assign cnt_clr   = (state_q == IDLE) || (state_q == CLEAR);
  assign cnt_limit = (state_q == SHOW) ? HOLD_LIMIT : BLINK_LIMIT;

  frame_tick_counter #(
    .CNT_W (CNT_W)
  ) u_frame_cnt (
    .clk     (clk),
    .rst_n   (rst_n),
    .en_i    (cnt_en),
    .clr_i   (cnt_clr),
    .limit_i (cnt_limit),
    .tc_o    (tc)
  );

  always_comb begin
    unique case (result_q)
      RES_TOO_EARLY: sel_pixel = end_pixel0;
      RES_WIN:       sel_pixel = end_pixel1;
      RES_LOSE:      sel_pixel = end_pixel2;
      default:       sel_pixel = WHITE;
    endcase
  end

`ifdef INVERT_BLINK_EN
  logic phase_q;

  // Phase is held at zero outside WAIT so every WAIT entry starts un-inverted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_q <= 1'b0;
    end else if (state_q != WAIT) begin
      phase_q <= 1'b0;
    end else if (tc) begin
      phase_q <= ~phase_q;
    end
  end

  assign wait_pixel = phase_q ? ~sel_pixel : sel_pixel;
`else
  assign wait_pixel = sel_pixel;
`endif

  // NOTE: every output of this block gets a default first, so no path leaves
  // a variable unassigned and no latch is inferred.
  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    pend_d   = pend_q;
    done_d   = 1'b0;
    oled_d   = BLACK;
    unique case (state_q)
      IDLE: begin
        oled_d = game_pixel;
        if (game_over) begin
          result_d = result;
          state_d  = SHOW;
        end
      end
      SHOW: begin
        oled_d = sel_pixel;
        if (tc) begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        oled_d = wait_pixel;
        if (frame_begin && (pend_q || btn_continue)) begin
          pend_d  = 1'b0;
          state_d = CLEAR;
        end else if (btn_continue) begin
          pend_d = 1'b1;
        end
      end
      CLEAR: begin
        oled_d = BLACK;
        if (frame_begin) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      result_q <= RES_TOO_EARLY;
      pend_q   <= 1'b0;
      oled_q   <= BLACK;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      pend_q   <= pend_d;
      oled_q   <= oled_d;
      done_q   <= done_d;
    end
  end

  assign oled_data = oled_q;
  assign busy      = (state_q != IDLE);
  assign done      = done_q;

endmodule : end_screen_sequencer

// File: tb/tb_end_screen_sequencer.sv
// Scoreboard bench for end_screen_sequencer: a frame-counting reference model
// pushes expected outputs each clock; the negedge checker pops and compares.
module tb_end_screen_sequencer;
  import end_screen_pkg::*;

  localparam int HOLD  = 4;
  localparam int BLINK = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        frame_begin = 1'b0;
  logic        game_over = 1'b0;
  logic [1:0]  result = 2'd0;
  logic        btn_continue = 1'b0;
  logic [15:0] game_pixel = 16'h0000;
  logic [15:0] end_pixel0 = 16'h001F;
  logic [15:0] end_pixel1 = 16'hF800;
  logic [15:0] end_pixel2 = 16'h5A3C;
  logic [15:0] oled_data;
  logic        busy;
  logic        done;

  always #5 clk = ~clk;

  end_screen_sequencer #(
    .HOLD_FRAMES  (HOLD),
    .BLINK_FRAMES (BLINK),
    .CNT_W        (8)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .frame_begin  (frame_begin),
    .game_over    (game_over),
    .result       (result),
    .btn_continue (btn_continue),
    .game_pixel   (game_pixel),
    .end_pixel0   (end_pixel0),
    .end_pixel1   (end_pixel1),
    .end_pixel2   (end_pixel2),
    .oled_data    (oled_data),
    .busy         (busy),
    .done         (done)
  );

  typedef struct packed {
    logic [15:0] oled;
    logic        busy;
    logic        done;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [15:0] screen_of(input logic [1:0] r);
    case (r)
      2'd0:    return end_pixel0;
      2'd1:    return end_pixel1;
      2'd2:    return end_pixel2;
      default: return 16'hFFFF;
    endcase
  endfunction

  // Reference model: tracks frames seen in SHOW and in WAIT as plain integers.
  state_e     m_state;
  logic [1:0] m_res;
  int         m_show_frames;
  int         m_wait_frames;
  bit         m_pend;
  exp_t       m_e;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_state       = IDLE;
      m_res         = 2'd0;
      m_show_frames = 0;
      m_wait_frames = 0;
      m_pend        = 1'b0;
      sb_q.delete();
    end else begin
      case (m_state)
        IDLE:  m_e.oled = game_pixel;
        SHOW:  m_e.oled = screen_of(m_res);
        WAIT: begin
          m_e.oled = screen_of(m_res);
`ifdef INVERT_BLINK_EN
          if (((m_wait_frames / BLINK) % 2) == 1) m_e.oled = ~m_e.oled;
`endif
        end
        default: m_e.oled = 16'h0000;
      endcase
      m_e.done = (m_state == CLEAR) && frame_begin;
      case (m_state)
        IDLE: if (game_over) begin
          m_res         = result;
          m_show_frames = 0;
          m_state       = SHOW;
        end
        SHOW: if (frame_begin) begin
          m_show_frames++;
          if (m_show_frames == HOLD) begin
            m_wait_frames = 0;
            m_pend        = 1'b0;
            m_state       = WAIT;
          end
        end
        WAIT: begin
          if (frame_begin && (m_pend || btn_continue)) m_state = CLEAR;
          else if (frame_begin) m_wait_frames++;
          else if (btn_continue) m_pend = 1'b1;
        end
        default: if (frame_begin) m_state = IDLE;
      endcase
      m_e.busy = (m_state != IDLE);
      sb_q.push_back(m_e);
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      check("rst_oled", oled_data, 16'h0000);
      check("rst_busy", 16'(busy), 16'd0);
      check("rst_done", 16'(done), 16'd0);
    end else if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check("oled", oled_data, e.oled);
      check("busy", 16'(busy), 16'(e.busy));
      check("done", 16'(done), 16'(e.done));
    end
  end

  task automatic cyc(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic frame();
    frame_begin = 1'b1;
    cyc();
    frame_begin = 1'b0;
    cyc(3);
  endtask

  task automatic start_game(input logic [1:0] r, input bit with_fb);
    result      = r;
    game_over   = 1'b1;
    frame_begin = with_fb;
    cyc();
    game_over   = 1'b0;
    frame_begin = 1'b0;
    result      = 2'd2;
    cyc(2);
  endtask

  initial begin
    cyc(3);
    @(negedge clk);
    #1 rst_n = 1'b1;
    cyc();

    // Live pass-through, fixed then varying pixels.
    game_pixel = 16'h07E0;
    cyc(3);
    repeat (6) begin
      game_pixel = 16'($urandom);
      cyc();
    end

    // TOO_EARLY screen; button during SHOW must be ignored.
    start_game(2'd0, 1'b0);
    frame();
    frame();
    btn_continue = 1'b1;
    cyc();
    btn_continue = 1'b0;
    frame();
    frame();
    repeat (3) frame();

    // Button in WAIT is pended until the next frame, then one blank frame.
    btn_continue = 1'b1;
    cyc();
    btn_continue = 1'b0;
    cyc(2);
    frame();
    frame();
    game_pixel = 16'h1234;
    cyc(3);

    // WIN screen with blinking WAIT; button and frame_begin together.
    start_game(2'd1, 1'b0);
    repeat (HOLD) frame();
    repeat (5) frame();
    frame_begin  = 1'b1;
    btn_continue = 1'b1;
    cyc();
    frame_begin  = 1'b0;
    btn_continue = 1'b0;
    cyc(2);
    frame();
    cyc(2);

    // Reserved result code, game_over coinciding with frame_begin, re-trigger ignored.
    start_game(2'd3, 1'b1);
    frame();
    result    = 2'd1;
    game_over = 1'b1;
    cyc();
    game_over = 1'b0;
    repeat (HOLD) frame();
    repeat (2) frame();
    btn_continue = 1'b1;
    cyc();
    btn_continue = 1'b0;
    frame();
    frame();

    // Reset taken in WAIT: outputs clear immediately, IDLE after release.
    start_game(2'd2, 1'b0);
    repeat (HOLD + 1) frame();
    #1 rst_n = 1'b0;
    #1;
    check("async_rst_oled", oled_data, 16'h0000);
    check("async_rst_busy", 16'(busy), 16'd0);
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b1;
    game_pixel = 16'hBEEF;
    cyc(4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_end_screen_sequencer
